// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared types, state codes, flag indices and condition evaluation for alu_sequencer.
package alu_seq_pkg;
  typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MOV, OP_XOR, OP_ANDN, OP_NOT} alu_op_e;
  typedef enum logic [1:0] {S_IDLE, S_READ, S_WAIT, S_WB} seq_state_e;
  typedef enum logic [1:0] {C_ALWAYS, C_Z, C_NZ, C_C} cond_e;
  localparam logic [1:0] IDLE = S_IDLE;
  localparam logic [1:0] READ = S_READ;
  localparam logic [1:0] WAIT = S_WAIT;
  localparam logic [1:0] WB = S_WB;
  localparam int FZ = 3;
  localparam int FN = 2;
  localparam int FC = 1;
  localparam int FV = 0;
  function automatic logic cond_ok(input logic [1:0] c, input logic [3:0] f);
    return c == C_Z ? f[FZ] : c == C_NZ ? !f[FZ] : c == C_C ? f[FC] : 1'b1;
  endfunction
endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: instruction handshake plus ALU operand/result bus between source, sequencer and ALU.
interface alu_seq_if;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] instr;
  logic [1:0] instr_cond;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [2:0] alu_control;
  logic [7:0] alu_result;
  logic       alu_z;
  logic       alu_n;
  logic       alu_c;
  logic       alu_v;
  modport master (
    output instr_valid, instr, instr_cond, alu_result, alu_z, alu_n, alu_c, alu_v,
    input  instr_ready, alu_a, alu_b, alu_control
  );
  modport slave (
    input  instr_valid, instr, instr_cond, alu_result, alu_z, alu_n, alu_c, alu_v,
    output instr_ready, alu_a, alu_b, alu_control
  );
endinterface

// File: rtl/alu_seq_regfile.sv
// alu_seq_regfile: 4x8 register file, single write port (write-back beats external load),
// two registered read ports and one combinational debug read port.
module alu_seq_regfile import alu_seq_pkg::*; #(
  parameter int NREGS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       we,
  input  logic [1:0] waddr,
  input  logic [7:0] wdata,
  input  logic       ld_en,
  input  logic [1:0] ld_addr,
  input  logic [7:0] ld_data,
  input  logic       rd_en,
  input  logic [1:0] ra,
  input  logic [1:0] rb,
  output logic [7:0] qa,
  output logic [7:0] qb,
  input  logic [1:0] dbg_addr,
  output logic [7:0] dbg_data
);
  logic [7:0] r [NREGS];
  logic [1:0] wa;
  logic [7:0] wd;
  always_comb begin
    wa = we ? waddr : ld_addr;
    wd = we ? wdata : ld_data;
    dbg_data = r[dbg_addr];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r <= '{default: '0};
      qa <= '0;
      qb <= '0;
    end else begin
      if (we || ld_en) r[wa] <= wd;
      if (rd_en) begin
        qa <= r[ra];
        qb <= r[rb];
      end
    end
  end
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: IDLE->READ->WAIT->WB sequencer feeding an 8-bit ALU from a 4x8 register file.
// Optional ALU_SEQ_COND_EN: conditional execution on instr_cond versus flags_q.
module alu_sequencer import alu_seq_pkg::*; #(
  parameter int ALU_WAIT = 3,
  parameter int NREGS = 4
) (
  input  logic       clk,
  input  logic       reset,
  alu_seq_if.slave   bus,
  output logic [3:0] flags_q,
  output logic       wb_valid,
  output logic [1:0] wb_addr,
  output logic [7:0] wb_data,
  input  logic       ld_en,
  input  logic [1:0] ld_addr,
  input  logic [7:0] ld_data,
  input  logic [1:0] dbg_addr,
  output logic [7:0] dbg_data,
  output logic       busy
);
  localparam int CW = ALU_WAIT > 1 ? $clog2(ALU_WAIT) : 1;
  logic [1:0] state;
  logic [7:0] ir;
  logic [CW-1:0] cnt;
  logic go;
  logic rd_en;
`ifdef ALU_SEQ_COND_EN
  logic [1:0] cq;
  assign go = cond_ok(cq, flags_q);
  always_ff @(posedge clk) begin
    if (reset) cq <= '0;
    else if (state == IDLE && bus.instr_valid) cq <= bus.instr_cond;
  end
`else
  assign go = 1'b1;
`endif
  always_comb begin
    bus.instr_ready = state == IDLE && !reset;
    busy = !bus.instr_ready;
    wb_valid = state == WB;
    wb_addr = wb_valid ? ir[4:3] : '0;
    wb_data = wb_valid ? bus.alu_result : '0;
    rd_en = state == READ && go;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ir <= '0;
      cnt <= '0;
      bus.alu_control <= '0;
      flags_q <= '0;
    end else begin
      if (state == IDLE && bus.instr_valid) begin
        ir <= bus.instr;
        state <= READ;
      end
      if (state == READ) begin
        state <= go ? WAIT : IDLE;
        cnt <= CW'(ALU_WAIT - 1);
        if (go) bus.alu_control <= ir[7:5];
      end
      if (state == WAIT) begin
        state <= cnt == '0 ? WB : WAIT;
        cnt <= cnt - 1'b1;
      end
      if (state == WB) begin
        state <= IDLE;
        if (ir[0]) begin
          flags_q[FZ] <= bus.alu_z;
          flags_q[FN] <= bus.alu_n;
          flags_q[FC] <= bus.alu_c;
          flags_q[FV] <= bus.alu_v;
        end
      end
    end
  end
  alu_seq_regfile #(.NREGS(NREGS)) u_rf (
    .clk(clk), .reset(reset),
    .we(wb_valid), .waddr(ir[4:3]), .wdata(bus.alu_result),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .rd_en(rd_en), .ra(ir[4:3]), .rb(ir[2:1]), .qa(bus.alu_a), .qb(bus.alu_b),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed stimulus with a write-back scoreboard; includes a behavioural 8-bit ALU.
module tb_alu_sequencer;
  import alu_seq_pkg::*;
  typedef struct {
    logic [1:0] a;
    logic [7:0] d;
    logic [3:0] f;
  } exp_t;
  logic clk = 0;
  logic reset = 1;
  logic [3:0] flags_q;
  logic wb_valid;
  logic [1:0] wb_addr;
  logic [7:0] wb_data;
  logic ld_en, dbg_dummy;
  logic [1:0] ld_addr, dbg_addr;
  logic [7:0] ld_data, dbg_data;
  logic busy;
  int checks = 0;
  int failures = 0;
  exp_t q[$];
  exp_t e;
  logic pend = 0;
  logic [3:0] pfl = '0;
  logic [3:0] fl;
  logic [8:0] s;
  int n;
  always #5 clk = ~clk;
  alu_seq_if bus();
  alu_sequencer dut (
    .clk(clk), .reset(reset), .bus(bus.slave),
    .flags_q(flags_q), .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .busy(busy)
  );
  always_comb begin
    s = '0;
    bus.alu_v = 1'b0;
    case (alu_op_e'(bus.alu_control))
      OP_ADD: begin
        s = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
        bus.alu_v = (bus.alu_a[7] == bus.alu_b[7]) && (s[7] != bus.alu_a[7]);
      end
      OP_SUB: begin
        s = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 9'd1;
        bus.alu_v = (bus.alu_a[7] != bus.alu_b[7]) && (s[7] != bus.alu_a[7]);
      end
      OP_AND:  s = {1'b0, bus.alu_a & bus.alu_b};
      OP_OR:   s = {1'b0, bus.alu_a | bus.alu_b};
      OP_MOV:  s = {1'b0, bus.alu_b};
      OP_XOR:  s = {1'b0, bus.alu_a ^ bus.alu_b};
      OP_ANDN: s = {1'b0, bus.alu_a & ~bus.alu_b};
      default: s = {1'b0, ~bus.alu_a};
    endcase
    bus.alu_result = s[7:0];
    bus.alu_z = s[7:0] == 8'h00;
    bus.alu_n = s[7];
    bus.alu_c = s[8];
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (pend) begin
      chk("flags", 32'(flags_q), 32'(pfl));
      pend = 0;
    end
    if (wb_valid) begin
      if (q.size() == 0) chk("unexpected_wb", 32'(wb_valid), 0);
      else begin
        e = q.pop_front();
        chk("wb_addr", 32'(wb_addr), 32'(e.a));
        chk("wb_data", 32'(wb_data), 32'(e.d));
        pfl = e.f;
        pend = 1;
      end
    end
  end
  task automatic ld(input logic [1:0] a, input logic [7:0] d);
    ld_en = 1;
    ld_addr = a;
    ld_data = d;
    @(posedge clk);
    #1 ld_en = 0;
  endtask
  task automatic accept(input logic [7:0] i, input logic [1:0] c, input logic drop);
    int k;
    bus.instr = i;
    bus.instr_cond = c;
    bus.instr_valid = 1;
    k = 0;
    while (!bus.instr_ready && k < 50) begin
      @(posedge clk);
      #1 k++;
    end
    if (k == 50) chk("accept_timeout", 32'(k), 0);
    @(posedge clk);
    #1 if (drop) bus.instr_valid = 0;
  endtask
  task automatic gap(output int g);
    g = 0;
    @(negedge clk);
    while (!bus.instr_ready && g < 50) begin
      g++;
      @(negedge clk);
    end
  endtask
  initial begin
    dbg_dummy = 0;
    bus.instr_valid = 0;
    bus.instr = '0;
    bus.instr_cond = '0;
    ld_en = 0;
    ld_addr = '0;
    ld_data = '0;
    dbg_addr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(bus.instr_ready), 0);
    chk("rst_busy", 32'(busy), 1);
    chk("rst_alu_a", 32'(bus.alu_a), 0);
    chk("rst_ctl", 32'(bus.alu_control), 0);
    chk("rst_flags", 32'(flags_q), 0);
    chk("rst_wb_valid", 32'(wb_valid), 0);
    @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("ready_after_rst", 32'(bus.instr_ready), 1);
    @(posedge clk);
    #1;
    ld(2'd1, 8'h05);
    ld(2'd2, 8'h03);
    q.push_back('{2'd1, 8'h08, 4'b0000});
    accept(8'h0D, 2'b00, 1);
    @(negedge clk);
    @(negedge clk);
    chk("t1_alu_a", 32'(bus.alu_a), 32'h05);
    chk("t1_alu_b", 32'(bus.alu_b), 32'h03);
    chk("t1_ctl", 32'(bus.alu_control), 0);
    repeat (3) @(negedge clk);
    chk("t1_wb_timing", 32'(wb_valid), 1);
    @(negedge clk);
    chk("t1_ready_again", 32'(bus.instr_ready), 1);
    ld(2'd1, 8'h03);
    ld(2'd2, 8'h03);
    q.push_back('{2'd1, 8'h00, 4'b1010});
    accept(8'h2D, 2'b00, 1);
    @(negedge clk);
    @(negedge clk);
    chk("t2_ctl", 32'(bus.alu_control), 1);
    gap(n);
    chk("t2_gap", 32'(n), 3);
    q.push_back('{2'd1, 8'hFD, 4'b1010});
    accept(8'h2C, 2'b00, 1);
    gap(n);
    chk("t2b_gap", 32'(n), 5);
    ld(2'd1, 8'h05);
    ld(2'd2, 8'h03);
`ifdef ALU_SEQ_COND_EN
    accept(8'h0D, 2'b10, 1);
    gap(n);
    chk("t3_skip_gap", 32'(n), 1);
    chk("t3_alu_a_hold", 32'(bus.alu_a), 32'h00);
    chk("t3_ctl_hold", 32'(bus.alu_control), 1);
    fl = 4'b1010;
`else
    q.push_back('{2'd1, 8'h08, 4'b0000});
    accept(8'h0D, 2'b10, 1);
    gap(n);
    chk("t3_exec_gap", 32'(n), 5);
    fl = 4'b0000;
`endif
    ld(2'd1, 8'h01);
    ld(2'd2, 8'h02);
    q.push_back('{2'd1, 8'h03, fl});
    q.push_back('{2'd1, 8'h05, fl});
    q.push_back('{2'd1, 8'h07, fl});
    for (int k = 0; k < 3; k++) begin
      accept(8'h0C, 2'b00, k == 2);
      gap(n);
      chk("t4_gap", 32'(n), 5);
    end
    ld(2'd1, 8'h03);
    ld(2'd2, 8'h03);
    q.push_back('{2'd1, 8'h00, 4'b1010});
    accept(8'h2D, 2'b00, 1);
    repeat (3) @(posedge clk);
    @(posedge clk);
    #1 ld_en = 1;
    ld_addr = 2'd1;
    ld_data = 8'hAA;
    @(posedge clk);
    #1 ld_en = 0;
    dbg_addr = 2'd1;
    @(negedge clk);
    chk("t6_wb_beats_ld", 32'(dbg_data), 32'h00);
    @(posedge clk);
    #1;
    ld(2'd3, 8'h5A);
    dbg_addr = 2'd3;
    #1 chk("t6_ld_r3", 32'(dbg_data), 32'h5A);
    ld(2'd1, 8'h05);
    ld(2'd2, 8'h03);
    accept(8'h2D, 2'b00, 1);
    repeat (3) @(negedge clk);
    chk("t5_in_wait", 32'(bus.alu_control), 1);
    @(posedge clk);
    #1 reset = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("t5_ready_rst", 32'(bus.instr_ready), 0);
    chk("t5_wb_valid", 32'(wb_valid), 0);
    chk("t5_alu_a", 32'(bus.alu_a), 0);
    chk("t5_alu_b", 32'(bus.alu_b), 0);
    chk("t5_ctl", 32'(bus.alu_control), 0);
    chk("t5_flags", 32'(flags_q), 0);
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 2'(i);
      #1 chk("t5_reg", 32'(dbg_data), 0);
    end
    @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("t5_ready_after", 32'(bus.instr_ready), 1);
    repeat (8) @(negedge clk);
    chk("sb_empty", 32'(q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
